lcplc_input_tagger: RTL

- Upstream stage of the LCPLC coder. Takes a plain AXI-Stream of hyperspectral samples and tags each one with the hierarchical end markers the coder consumes: x_last_r, x_last_s, x_last_b, x_last_i.
- Geometry comes from configuration ports and is latched at the start of each image.
- Sample order within an image: slice, then band, then row, then column (column fastest).

---
 rtl/lcplc_input_tagger.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lcplc_input_tagger.sv
// Tags a raw hyperspectral AXI-Stream with row/band/slice/image end markers for the LCPLC coder.
// Optional build macro LCPLC_TAGGER_CHECK_EN enables the upstream in_last cross-check.
module lcplc_input_tagger #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COL_WIDTH   = 12,
    parameter int unsigned ROW_WIDTH   = 12,
    parameter int unsigned BAND_WIDTH  = 10,
    parameter int unsigned SLICE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COL_WIDTH-1:0]   cfg_cols_m1,
    input  logic [ROW_WIDTH-1:0]   cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]  cfg_bands_m1,
    input  logic [SLICE_WIDTH-1:0] cfg_slices_m1,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   x_valid,
    input  logic                   x_ready,
    output logic [DATA_WIDTH-1:0]  x_data,
    output logic                   x_last_r,
    output logic                   x_last_b,
    output logic                   x_last_s,
    output logic                   x_last_i,
    output logic                   err_last_mismatch,
    output logic                   busy
);

    logic                   x_valid_q, x_valid_d;
    logic [DATA_WIDTH-1:0]  x_data_q, x_data_d;
    logic                   last_r_q, last_r_d;
    logic                   last_b_q, last_b_d;
    logic                   last_s_q, last_s_d;
    logic                   last_i_q, last_i_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [BAND_WIDTH-1:0]  band_q, band_d;
    logic [SLICE_WIDTH-1:0] slice_q, slice_d;

    logic [COL_WIDTH-1:0]   cols_m1_q, cols_m1_d;
    logic [ROW_WIDTH-1:0]   rows_m1_q, rows_m1_d;
    logic [BAND_WIDTH-1:0]  bands_m1_q, bands_m1_d;
    logic [SLICE_WIDTH-1:0] slices_m1_q, slices_m1_d;

    logic                   accept;
    logic [COL_WIDTH-1:0]   cols_m1_c;
    logic [ROW_WIDTH-1:0]   rows_m1_c;
    logic [BAND_WIDTH-1:0]  bands_m1_c;
    logic [SLICE_WIDTH-1:0] slices_m1_c;
    logic                   last_r_c, last_b_c, last_s_c, last_i_c;

    assign in_ready = !x_valid_q || x_ready;
    assign accept   = in_valid && in_ready;

    // The first sample of an image sees the live configuration it is about to latch.
    always_comb begin
        cols_m1_c   = busy_q ? cols_m1_q   : cfg_cols_m1;
        rows_m1_c   = busy_q ? rows_m1_q   : cfg_rows_m1;
        bands_m1_c  = busy_q ? bands_m1_q  : cfg_bands_m1;
        slices_m1_c = busy_q ? slices_m1_q : cfg_slices_m1;
        last_r_c    = (col_q == cols_m1_c);
        last_b_c    = last_r_c && (row_q == rows_m1_c);
        last_s_c    = last_b_c && (band_q == bands_m1_c);
        last_i_c    = last_s_c && (slice_q == slices_m1_c);
    end

    always_comb begin
        x_valid_d   = x_valid_q;
        x_data_d    = x_data_q;
        last_r_d    = last_r_q;
        last_b_d    = last_b_q;
        last_s_d    = last_s_q;
        last_i_d    = last_i_q;
        busy_d      = busy_q;
        col_d       = col_q;
        row_d       = row_q;
        band_d      = band_q;
        slice_d     = slice_q;
        cols_m1_d   = cols_m1_q;
        rows_m1_d   = rows_m1_q;
        bands_m1_d  = bands_m1_q;
        slices_m1_d = slices_m1_q;
`ifdef LCPLC_TAGGER_CHECK_EN
        err_d       = err_q || (accept && (in_last != last_i_c));
`else
        // Reset value of err_q is 0, so this holds the flag at 0 forever.
        err_d       = err_q && in_last;
`endif

        if (accept) begin
            x_valid_d = 1'b1;
            x_data_d  = in_data;
            last_r_d  = last_r_c;
            last_b_d  = last_b_c;
            last_s_d  = last_s_c;
            last_i_d  = last_i_c;
            busy_d    = !last_i_c;
            if (!busy_q) begin
                cols_m1_d   = cfg_cols_m1;
                rows_m1_d   = cfg_rows_m1;
                bands_m1_d  = cfg_bands_m1;
                slices_m1_d = cfg_slices_m1;
            end
            // Mixed-radix advance; a last_i sample returns every counter to 0.
            col_d = last_r_c ? '0 : col_q + COL_WIDTH'(1);
            if (last_r_c) row_d   = last_b_c ? '0 : row_q + ROW_WIDTH'(1);
            if (last_b_c) band_d  = last_s_c ? '0 : band_q + BAND_WIDTH'(1);
            if (last_s_c) slice_d = last_i_c ? '0 : slice_q + SLICE_WIDTH'(1);
        end else if (x_ready) begin
            x_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid_q   <= 1'b0;
            x_data_q    <= '0;
            last_r_q    <= 1'b0;
            last_b_q    <= 1'b0;
            last_s_q    <= 1'b0;
            last_i_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            band_q      <= '0;
            slice_q     <= '0;
            cols_m1_q   <= '0;
            rows_m1_q   <= '0;
            bands_m1_q  <= '0;
            slices_m1_q <= '0;
        end else begin
            x_valid_q   <= x_valid_d;
            x_data_q    <= x_data_d;
            last_r_q    <= last_r_d;
            last_b_q    <= last_b_d;
            last_s_q    <= last_s_d;
            last_i_q    <= last_i_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            col_q       <= col_d;
            row_q       <= row_d;
            band_q      <= band_d;
            slice_q     <= slice_d;
            cols_m1_q   <= cols_m1_d;
            rows_m1_q   <= rows_m1_d;
            bands_m1_q  <= bands_m1_d;
            slices_m1_q <= slices_m1_d;
        end
    end

    assign x_valid           = x_valid_q;
    assign x_data            = x_data_q;
    assign x_last_r          = last_r_q;
    assign x_last_b          = last_b_q;
    assign x_last_s          = last_s_q;
    assign x_last_i          = last_i_q;
    assign err_last_mismatch = err_q;
    // Busy also covers the accept cycle, so a 1x1x1x1 image still shows a one-cycle pulse.
    assign busy              = busy_q || accept;

endmodule
